regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised register file: NUM_REGS x DATA_W, 1 write port, 2 registered read ports.
//  Replaces the fixed 4x32 file.
//  Adds write-to-read bypass, an optional hardwired-zero register 0, and a per-register
//  pending-write scoreboard, so decode can detect RAW hazards against in-flight results.
//  Sits between decode (reads, mark) and writeback (write).
// PARAMETERS
//  DATA_W    32  register width in bits
//  NUM_REGS  4   register count; power of 2, >= 2
//  ZERO_REG  0   1: register 0 reads 0, ignores writes, never busy
//  AW        $clog2(NUM_REGS)  address width (derived; do not override)
// PORTS
//  clk        in   1       single clock; all state changes on rising edge
//  reset      in   1       synchronous, active-low
//  we         in   1       write enable (writeback)
//  waddr      in   AW      write register index
//  wdata      in   DATA_W  write data
//  raddr1     in   AW      read port 1 index
//  raddr2     in   AW      read port 2 index
//  mark_en    in   1       set scoreboard bit of mark_addr (decode issued producer)
//  mark_addr  in   AW      destination index being marked pending
//  rdata1     out  DATA_W  read data 1, registered
//  rdata2     out  DATA_W  read data 2, registered
//  busy1      out  1       pending bit of raddr1, registered, aligned with rdata1
//  busy2      out  1       pending bit of raddr2, registered, aligned with rdata2
// BEHAVIOUR
//  - Reset (reset==0 at edge):
//    - all registers <= 0, all pending bits <= 0, rdata1/2 <= 0, busy1/2 <= 0.
//    - Overrides we and mark_en in the same cycle; an in-flight mark or write is dropped.
//  - Write: at edge with we=1, reg[waddr] <= wdata.
//    - Ignored when ZERO_REG=1 and waddr=0.
//  - Read latency = 1 cycle: rdataN at edge k+1 reflects raddrN sampled at edge k.
//  - Bypass: if we=1 and waddr==raddrN in the same cycle, rdataN <= wdata (new value, not old).
//    - Not applied for addr 0 when ZERO_REG=1.
//  - Both read ports may address the same register; both return the same value.
//  - Scoreboard per register i:
//    - mark_en & mark_addr==i           -> pend[i] <= 1
//    - we & waddr==i & !(mark same i)   -> pend[i] <= 0
//    - mark and write to same i in one cycle: mark wins, pend[i] stays 1 (newer producer
//      issued). The data write still occurs.
//  - busyN <= pend[raddrN] next-state, i.e. includes this cycle's mark/clear.
//    - Hence a write clearing i makes busyN=0 in the same cycle rdataN gets bypassed wdata.
//    - A mark of i makes busyN=1 immediately.
//  - ZERO_REG=1: mark of addr 0 ignored; busyN=0 and rdataN=0 whenever raddrN=0.
//  - Out-of-range indices cannot occur (NUM_REGS is a power of 2).
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Shared header regfile_defs.vh: DATA_W/NUM_REGS defaults, AW derivation macro,
//    ZERO_REG default.
//  - Sub-module reg_scoreboard (NUM_REGS, AW):
//    - owns pend[], mark/clear priority, and registered busy lookups for two ports.
//  - Top holds the storage array, write decode, bypass muxes and output registers.
// TESTING
//  1. Reset: hold reset=0 for 2 cycles with we=1, mark_en=1
//     -> rdata1/2=0, busy1/2=0, then all regs read 0.
//  2. Write/read: we, waddr=2, wdata=32'hDEADBEEF; next cycle raddr1=2
//     -> rdata1=DEADBEEF one cycle later.
//  3. Bypass: same-cycle we, waddr=3, wdata=32'h1234, raddr1=raddr2=3
//     -> next cycle rdata1=rdata2=1234, old value never visible.
//  4. Scoreboard: mark_addr=1; then raddr1=1 -> busy1=1; then we waddr=1 wdata=5 with raddr1=1
//     -> busy1=0, rdata1=5.
//  5. Mark+write collision: mark_addr=waddr=2 same cycle
//     -> reg2 updated, busy on later read of 2 stays 1 until next write.
//  6. ZERO_REG=1, NUM_REGS=8: we waddr=0 wdata=FFFFFFFF, mark_addr=0
//     -> raddr1=0 gives rdata1=0, busy1=0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the regfile_sb register file.
//   DEF_DATA_W   : default register width
//   DEF_NUM_REGS : default register count (power of 2, >= 2)
//   DEF_ZERO_REG : default for hardwired-zero register 0 (0 = off)
//   addr_w()     : address width derived from a register count
package regfile_sb_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_REGS = 4;
   localparam int unsigned DEF_ZERO_REG = 0;

   // Address width for a register count; at least 1 bit.
   function automatic int unsigned addr_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard for regfile_sb.
// Tracks one pending bit per register: decode marks a destination when it
// issues a producer, writeback clears it. A mark and a clear of the same
// register in one cycle leave it pending, since the mark belongs to a newer
// producer. busy1/busy2 are registered lookups of the next-state bits.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   we, waddr           : writeback write (clears pending)
//   mark_en, mark_addr  : decode mark (sets pending)
//   raddr1, raddr2      : lookup indices
//   busy1, busy2        : registered pending bits of raddr1/raddr2
module regfile_sb_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned AW       = addr_w(NUM_REGS),
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic          mark_en,
   input  logic [AW-1:0] mark_addr,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic          busy1,
   output logic          busy2
);

   localparam bit ZR = (ZERO_REG != 0);

   logic [NUM_REGS-1:0] pend_d, pend_q;
   logic                busy1_d, busy1_q;
   logic                busy2_d, busy2_q;

   // Next pending state: clear on write, then mark overrides.
   always_comb begin
      pend_d = pend_q;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (we && (waddr == AW'(i))) pend_d[i] = 1'b0;
         if (mark_en && (mark_addr == AW'(i))) pend_d[i] = 1'b1;
      end
      if (ZR) pend_d[0] = 1'b0;
      busy1_d = pend_d[raddr1];
      busy2_d = pend_d[raddr2];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_q  <= '0;
         busy1_q <= 1'b0;
         busy2_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         busy1_q <= busy1_d;
         busy2_q <= busy2_d;
      end
   end

   assign busy1 = busy1_q;
   assign busy2 = busy2_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, optional hardwired
// zero register and a pending-write scoreboard for RAW hazard detection.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   we, waddr, wdata    : write port (writeback)
//   raddr1, raddr2      : read indices, sampled each edge
//   mark_en, mark_addr  : scoreboard mark from decode
//   rdata1, rdata2      : registered read data (1-cycle latency, bypassed)
//   busy1, busy2        : registered pending bits aligned with rdata1/rdata2
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG,
   parameter int unsigned AW       = addr_w(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr1,
   input  logic [AW-1:0]     raddr2,
   input  logic              mark_en,
   input  logic [AW-1:0]     mark_addr,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy1,
   output logic              busy2
);

   localparam bit ZR = (ZERO_REG != 0);

   logic [DATA_W-1:0] mem_d [NUM_REGS];
   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] rdata1_d, rdata1_q;
   logic [DATA_W-1:0] rdata2_d, rdata2_q;
   logic              wr_ok_c;
   logic              mark_ok_c;

   // Writes and marks to register 0 are dropped when it is hardwired.
   assign wr_ok_c   = we && !(ZR && (waddr == '0));
   assign mark_ok_c = mark_en && !(ZR && (mark_addr == '0));

   // Storage update and bypassed read muxes.
   always_comb begin
      mem_d = mem_q;
      if (wr_ok_c) mem_d[waddr] = wdata;

      if (ZR && (raddr1 == '0))               rdata1_d = '0;
      else if (wr_ok_c && (waddr == raddr1)) rdata1_d = wdata;
      else                                   rdata1_d = mem_q[raddr1];

      if (ZR && (raddr2 == '0))               rdata2_d = '0;
      else if (wr_ok_c && (waddr == raddr2)) rdata2_d = wdata;
      else                                   rdata2_d = mem_q[raddr2];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         mem_q    <= mem_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

   assign rdata1 = rdata1_q;
   assign rdata2 = rdata2_q;

   regfile_sb_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .we        (wr_ok_c),
      .waddr     (waddr),
      .mark_en   (mark_ok_c),
      .mark_addr (mark_addr),
      .raddr1    (raddr1),
      .raddr2    (raddr2),
      .busy1     (busy1),
      .busy2     (busy2)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (4x32 plain, 8x32 with zero register)
// driven with the same stimulus and checked every cycle against an
// array-based model, plus literal expectations for the directed scenarios.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus; instance A uses the low 2 address bits.
   logic        d_rst;
   logic        d_we;
   logic [2:0]  d_wa;
   logic [31:0] d_wd;
   logic [2:0]  d_r1, d_r2;
   logic        d_mk;
   logic [2:0]  d_ma;

   logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
   logic        busy1_a, busy2_a, busy1_b, busy2_b;

   regfile_sb #(.DATA_W(32), .NUM_REGS(4), .ZERO_REG(0)) dut_a (
      .clk(clk), .reset(d_rst), .we(d_we), .waddr(d_wa[1:0]), .wdata(d_wd),
      .raddr1(d_r1[1:0]), .raddr2(d_r2[1:0]), .mark_en(d_mk), .mark_addr(d_ma[1:0]),
      .rdata1(rdata1_a), .rdata2(rdata2_a), .busy1(busy1_a), .busy2(busy2_a));

   regfile_sb #(.DATA_W(32), .NUM_REGS(8), .ZERO_REG(1)) dut_b (
      .clk(clk), .reset(d_rst), .we(d_we), .waddr(d_wa), .wdata(d_wd),
      .raddr1(d_r1), .raddr2(d_r2), .mark_en(d_mk), .mark_addr(d_ma),
      .rdata1(rdata1_b), .rdata2(rdata2_b), .busy1(busy1_b), .busy2(busy2_b));

   // Model state: index 0 = instance A, 1 = instance B.
   logic [31:0] m_reg  [2][8];
   bit          m_pend [2][8];
   logic [31:0] e_rd1 [2];
   logic [31:0] e_rd2 [2];
   bit          e_b1  [2];
   bit          e_b2  [2];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the register file as seen from outside.
   task automatic model_step(input int d);
      int  n, wa, r1, r2, ma;
      bit  zr, wr_ok, mk_ok;
      bit  np [8];
      n  = (d == 0) ? 4 : 8;
      zr = (d == 1);
      wa = int'(d_wa) % n;
      r1 = int'(d_r1) % n;
      r2 = int'(d_r2) % n;
      ma = int'(d_ma) % n;
      if (!d_rst) begin
         for (int i = 0; i < 8; i++) begin
            m_reg[d][i]  = '0;
            m_pend[d][i] = 0;
         end
         e_rd1[d] = '0; e_rd2[d] = '0; e_b1[d] = 0; e_b2[d] = 0;
         return;
      end
      wr_ok = d_we && !(zr && wa == 0);
      mk_ok = d_mk && !(zr && ma == 0);
      for (int i = 0; i < 8; i++) np[i] = m_pend[d][i];
      if (wr_ok) np[wa] = 0;
      if (mk_ok) np[ma] = 1;
      e_rd1[d] = (zr && r1 == 0) ? 32'h0 : (wr_ok && wa == r1) ? d_wd : m_reg[d][r1];
      e_rd2[d] = (zr && r2 == 0) ? 32'h0 : (wr_ok && wa == r2) ? d_wd : m_reg[d][r2];
      e_b1[d]  = np[r1];
      e_b2[d]  = np[r2];
      if (wr_ok) m_reg[d][wa] = d_wd;
      for (int i = 0; i < 8; i++) m_pend[d][i] = np[i];
   endtask

   task automatic compare_all();
      check("a.rdata1", rdata1_a, e_rd1[0]);
      check("a.rdata2", rdata2_a, e_rd2[0]);
      check("a.busy1", 32'(busy1_a), 32'(e_b1[0]));
      check("a.busy2", 32'(busy2_a), 32'(e_b2[0]));
      check("b.rdata1", rdata1_b, e_rd1[1]);
      check("b.rdata2", rdata2_b, e_rd2[1]);
      check("b.busy1", 32'(busy1_b), 32'(e_b1[1]));
      check("b.busy2", 32'(busy2_b), 32'(e_b2[1]));
   endtask

   task automatic drive(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                        input int r1, input int r2, input bit mk, input int ma);
      d_rst = rst; d_we = we; d_wa = 3'(wa); d_wd = wd;
      d_r1 = 3'(r1); d_r2 = 3'(r2); d_mk = mk; d_ma = 3'(ma);
   endtask

   // Advance one edge, update the model, compare just after the edge.
   task automatic step();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare_all();
   endtask

   initial begin
      drive(0, 1, 2, 32'hAAAA_AAAA, 2, 2, 1, 2);

      // Reset held two cycles while write and mark are asserted.
      step();
      step();
      check("rst.a.rdata1", rdata1_a, 32'h0);
      check("rst.a.busy1", 32'(busy1_a), 32'h0);
      check("rst.b.rdata2", rdata2_b, 32'h0);
      check("rst.b.busy2", 32'(busy2_b), 32'h0);
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 32'h0, i, 7 - i, 0, 0);
         step();
         check("rst.b.regs", rdata1_b, 32'h0);
         check("rst.a.regs", rdata2_a, 32'h0);
      end

      // Plain write then read.
      drive(1, 1, 2, 32'hDEAD_BEEF, 0, 0, 0, 0); step();
      drive(1, 0, 0, 32'h0, 2, 2, 0, 0);         step();
      check("wr.a.rdata1", rdata1_a, 32'hDEAD_BEEF);
      check("wr.b.rdata2", rdata2_b, 32'hDEAD_BEEF);

      // Bypass: same-cycle write and read return the new value on both ports.
      drive(1, 1, 3, 32'h1111, 0, 0, 0, 0);   step();
      drive(1, 1, 3, 32'h1234, 3, 3, 0, 0);   step();
      check("byp.a.rdata1", rdata1_a, 32'h1234);
      check("byp.a.rdata2", rdata2_a, 32'h1234);

      // Scoreboard mark, busy lookup, and clear by write with bypass.
      drive(1, 0, 0, 32'h0, 0, 0, 1, 1);      step();
      drive(1, 0, 0, 32'h0, 1, 1, 0, 0);      step();
      check("sb.a.busy1", 32'(busy1_a), 32'h1);
      drive(1, 1, 1, 32'h5, 1, 1, 0, 0);      step();
      check("sb.a.busy1_clr", 32'(busy1_a), 32'h0);
      check("sb.a.rdata1", rdata1_a, 32'h5);

      // Mark and write to the same register: data lands, pending stays set.
      drive(1, 1, 2, 32'h77, 0, 0, 1, 2);     step();
      drive(1, 0, 0, 32'h0, 2, 2, 0, 0);      step();
      check("col.a.rdata1", rdata1_a, 32'h77);
      check("col.a.busy1", 32'(busy1_a), 32'h1);
      step();
      check("col.a.busy1_hold", 32'(busy1_a), 32'h1);
      drive(1, 1, 2, 32'h88, 2, 0, 0, 0);     step();
      check("col.a.busy1_clr", 32'(busy1_a), 32'h0);
      check("col.a.rdata1_new", rdata1_a, 32'h88);

      // Hardwired zero register on instance B; instance A treats 0 normally.
      drive(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0); step();
      check("zr.b.rdata1", rdata1_b, 32'h0);
      check("zr.b.busy1", 32'(busy1_b), 32'h0);
      drive(1, 0, 0, 32'h0, 0, 0, 0, 0);         step();
      check("zr.b.rdata1_later", rdata1_b, 32'h0);
      check("zr.b.busy1_later", 32'(busy1_b), 32'h0);
      check("zr.a.rdata1", rdata1_a, 32'hFFFF_FFFF);
      check("zr.a.busy1", 32'(busy1_a), 32'h1);

      // Randomised traffic with occasional reset.
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 7)), $urandom(),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
